// File: rtl/double_buffer_ctrl.sv
// Ping-pong sequencer for double_buffer_array: loads producer vectors into the
// inactive buffer, swaps when the consumer has released the active one.
module double_buffer_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] in_data,
  output logic                              load_en,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] data_in_flat,
  output logic                              swap_buffers,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              active_sel,
  output logic [COUNT_WIDTH-1:0]            swap_count
);

  // Encoding is {pend, act}: bit 1 = inactive buffer full, bit 0 = active buffer valid.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_PEND   = 2'b10,
    ST_FULL   = 2'b11
  } state_e;

  state_e                 state_q, state_d;
  logic                   sel_q, sel_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic pend, act, load, swap, out_fire;

  always_comb begin
    pend         = state_q[1];
    act          = state_q[0];
    in_ready     = ~pend & ~flush;
    load         = in_valid & in_ready;
    swap         = pend & (~act | out_ready) & ~flush;
    out_fire     = act & out_ready;
    load_en      = load;
    swap_buffers = swap;
    out_valid    = act;
    active_sel   = sel_q;
    swap_count   = cnt_q;
    data_in_flat = in_data;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (swap) begin
      sel_d = ~sel_q;
      cnt_d = cnt_q + COUNT_WIDTH'(1);
    end
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY:  if (load) state_d = ST_PEND;
        ST_ACTIVE: begin
          if (load)          state_d = out_fire ? ST_PEND : ST_FULL;
          else if (out_fire) state_d = ST_EMPTY;
        end
        ST_PEND:   if (swap) state_d = ST_ACTIVE;
        // Consume and swap together keep the output valid: no bubble.
        ST_FULL:   if (swap) state_d = ST_ACTIVE;
        default:   state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_double_buffer_ctrl.sv
// Directed bench for double_buffer_ctrl with a behavioural two-buffer array
// model so loaded vectors can be followed through to the consumer side.
module tb_double_buffer_ctrl;

  localparam int DW = 8;
  localparam int MS = 3;
  localparam int VW = DW * MS;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, in_valid, out_ready;
  logic [VW-1:0] in_data;

  logic          in_ready, load_en, swap_buffers, out_valid, active_sel;
  logic [VW-1:0] data_in_flat;
  logic [15:0]   swap_count;

  logic          n_in_ready, n_load_en, n_swap_buffers, n_out_valid, n_active_sel;
  logic [VW-1:0] n_data_in_flat;
  logic [1:0]    n_swap_count;

  always #5 clk = ~clk;

  double_buffer_ctrl #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .load_en(load_en), .data_in_flat(data_in_flat),
    .swap_buffers(swap_buffers), .out_valid(out_valid), .out_ready(out_ready),
    .active_sel(active_sel), .swap_count(swap_count)
  );

  double_buffer_ctrl #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS), .COUNT_WIDTH(2)) dut_narrow (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .load_en(n_load_en), .data_in_flat(n_data_in_flat),
    .swap_buffers(n_swap_buffers), .out_valid(n_out_valid), .out_ready(out_ready),
    .active_sel(n_active_sel), .swap_count(n_swap_count)
  );

  // Behavioural stand-in for double_buffer_array.
  logic [VW-1:0] bufs [2];
  logic          arr_sel;
  logic [VW-1:0] arr_out;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      arr_sel <= 1'b0;
    end else begin
      if (load_en)      bufs[~arr_sel] <= data_in_flat;
      if (swap_buffers) arr_sel        <= ~arr_sel;
    end
  end
  assign arr_out = bufs[arr_sel];

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic          iv;
    logic [VW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          e_ir;
    logic          e_ld;
    logic          e_sw;
    logic          e_ov;
    logic          e_sel;
    logic [15:0]   e_cnt;
    logic [VW-1:0] e_out;
  } vec_t;

  localparam logic [VW-1:0] VA = {8'd30, 8'd20, 8'd10};
  localparam logic [VW-1:0] VB = {8'd60, 8'd50, 8'd40};
  localparam logic [VW-1:0] VC = 24'h0C0B0A;
  localparam logic [VW-1:0] VD = 24'h0F0E0D;
  localparam logic [VW-1:0] VE = 24'h121110;
  localparam logic [VW-1:0] VF = 24'h151413;
  localparam logic [VW-1:0] VG = 24'h181716;
  localparam logic [VW-1:0] VH = 24'h1B1A19;
  localparam logic [VW-1:0] XX = 24'h0;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int loads, swaps, cyc;

    //          iv  data ordy fl  ir  ld  sw  ov  sel cnt     out
    // Single vector, consumer stalled: load, swap next cycle, then valid.
    vecs[0]  = '{1'b1, VA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, XX};
    vecs[1]  = '{1'b0, XX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, XX};
    vecs[2]  = '{1'b0, XX, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, VA};
    // Second vector while first held: FULL, back-pressure, then consume+swap.
    vecs[3]  = '{1'b1, VB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, VA};
    vecs[4]  = '{1'b1, VB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1, VA};
    vecs[5]  = '{1'b0, XX, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, VA};
    vecs[6]  = '{1'b0, XX, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, VB};
    // Four-vector stream with in_valid and out_ready high: four swaps.
    vecs[7]  = '{1'b1, VC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, VB};
    vecs[8]  = '{1'b1, VD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, XX};
    vecs[9]  = '{1'b1, VD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd3, VC};
    vecs[10] = '{1'b1, VE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd3, XX};
    vecs[11] = '{1'b1, VE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4, VD};
    vecs[12] = '{1'b1, VF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, XX};
    vecs[13] = '{1'b1, VF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5, VE};
    vecs[14] = '{1'b0, XX, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd5, XX};
    vecs[15] = '{1'b0, XX, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd6, VF};
    // Reach FULL, then flush with in_valid and out_ready high: nothing issued.
    vecs[16] = '{1'b1, VG, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd6, VF};
    vecs[17] = '{1'b1, VG, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd6, VF};
    vecs[18] = '{1'b0, XX, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd6, XX};
    // Load one more to leave the controller in PEND.
    vecs[19] = '{1'b1, VH, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd6, XX};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    check("rst_in_ready",     32'(in_ready),     32'd1);
    check("rst_out_valid",    32'(out_valid),    32'd0);
    check("rst_load_en",      32'(load_en),      32'd0);
    check("rst_swap_buffers", 32'(swap_buffers), 32'd0);
    check("rst_active_sel",   32'(active_sel),   32'd0);
    check("rst_swap_count",   32'(swap_count),   32'd0);
    step();
    rst = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].d;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      #1;
      check($sformatf("v%0d_in_ready", i),   32'(in_ready),     32'(vecs[i].e_ir));
      check($sformatf("v%0d_load_en", i),    32'(load_en),      32'(vecs[i].e_ld));
      check($sformatf("v%0d_swap", i),       32'(swap_buffers), 32'(vecs[i].e_sw));
      check($sformatf("v%0d_out_valid", i),  32'(out_valid),    32'(vecs[i].e_ov));
      check($sformatf("v%0d_active_sel", i), 32'(active_sel),   32'(vecs[i].e_sel));
      check($sformatf("v%0d_swap_count", i), 32'(swap_count),   32'(vecs[i].e_cnt));
      check($sformatf("v%0d_narrow_cnt", i), 32'(n_swap_count), 32'(vecs[i].e_cnt[1:0]));
      if (vecs[i].e_ov)
        check($sformatf("v%0d_array_out", i), 32'(arr_out), 32'(vecs[i].e_out));
      step();
    end

    // Controller now in PEND: swap requested; async reset must clear it with no edge.
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    check("pend_swap_before_rst", 32'(swap_buffers), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_swap",      32'(swap_buffers), 32'd0);
    check("async_rst_in_ready",  32'(in_ready),     32'd1);
    check("async_rst_out_valid", 32'(out_valid),    32'd0);
    check("async_rst_sel",       32'(active_sel),   32'd0);
    check("async_rst_count",     32'(swap_count),   32'd0);
    step();
    rst = 1'b1;
    step();

    // Five vectors streamed from reset: 16-bit count reaches 5, 2-bit count wraps to 1.
    loads = 0; swaps = 0; cyc = 0;
    out_ready = 1'b1;
    while (swaps < 5 && cyc < 40) begin
      in_valid = (loads < 5);
      in_data  = VW'(loads + 1) * 24'h010101;
      #1;
      check("stream_no_overlap", 32'(load_en & swap_buffers), 32'd0);
      check("stream_passthru",   32'(data_in_flat),           32'(in_data));
      if (load_en)      loads++;
      if (swap_buffers) swaps++;
      cyc++;
      step();
    end
    in_valid = 1'b0;
    #1;
    check("stream_swaps_seen",  32'(swaps),        32'd5);
    check("stream_count_wide",  32'(swap_count),   32'd5);
    check("stream_count_narrow",32'(n_swap_count), 32'd1);
    check("stream_sel_wide",    32'(active_sel),   32'd1);
    check("stream_sel_narrow",  32'(n_active_sel), 32'd1);
    check("stream_last_out",    32'(arr_out),      32'(24'h050505));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
